// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage chain and its users.
package pipe_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int STAGES_MAX    = 16;

    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake of the pipeline stage chain: input side at stage 0,
// output side at the oldest stage.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32
);

    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline register: a valid bit plus a payload that only loads alongside a valid item.
module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Flush wins over both hold and load; a killed item never reaches the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= in_valid;
            end
            if (load && in_valid && !flush) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers with stall, flush, bubble squeeze and
// per-stage taps for forwarding and hazard logic.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter bit COLLAPSE = 1'b1,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    pipe_stage_chain_if.slave         bus,
    input  logic [STAGES-1:0]         stall_i,
    input  logic [STAGES-1:0]         flush_i,
    output logic [STAGES-1:0]         stage_valid_o,
    output logic [STAGES*WIDTH-1:0]   stage_data_o,
    output logic [occ_w(STAGES)-1:0]  occupancy_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int OCC_W = occ_w(STAGES);

    logic [STAGES-1:0] blocked;
    logic [STAGES-1:0] stage_in_valid;
    logic              in_ready;

    // Backpressure ripples from the oldest stage towards stage 0. With COLLAPSE an
    // empty stage never blocks, so a bubble can be squeezed out under a stall.
    always_comb begin
        blocked = '1;
        if (start_i) begin
            if (COLLAPSE) begin
                blocked[STAGES-1] = stage_valid_o[STAGES-1]
                                  & (stall_i[STAGES-1] | ~bus.out_ready_i);
            end else begin
                blocked[STAGES-1] = stall_i[STAGES-1]
                                  | (stage_valid_o[STAGES-1] & ~bus.out_ready_i);
            end
            for (int k = STAGES - 2; k >= 0; k--) begin
                if (COLLAPSE) begin
                    blocked[k] = stage_valid_o[k] & (stall_i[k] | blocked[k+1]);
                end else begin
                    blocked[k] = stall_i[k] | blocked[k+1];
                end
            end
        end
    end

    assign in_ready        = ~blocked[0] & start_i;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = stage_valid_o[STAGES-1];
    assign bus.out_data_o  = stage_data_o[(STAGES-1)*WIDTH +: WIDTH];

    always_comb begin
        stage_in_valid    = '0;
        stage_in_valid[0] = bus.in_valid_i & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            stage_in_valid[k] = stage_valid_o[k-1] & ~blocked[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        if (k == 0) begin : g_head
            assign d_in = bus.in_data_i;
        end else begin : g_body
            assign d_in = stage_data_o[(k-1)*WIDTH +: WIDTH];
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk_i),
            .rst_n    (rst_i),
            .load     (~blocked[k]),
            .in_valid (stage_in_valid[k]),
            .in_data  (d_in),
            .flush    (flush_i[k]),
            .valid    (stage_valid_o[k]),
            .data     (stage_data_o[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy_o = occupancy_o + OCC_W'(stage_valid_o[k]);
        end
    end

    // Counts cycles where the producer offers an item the chain cannot take; saturates.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (bus.in_valid_i && !in_ready && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboarded bench: a collapsing (CNT_W=4) and a strict (CNT_W=16) chain share stimulus.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b1;
    logic [STAGES-1:0]  stall = '0;
    logic [STAGES-1:0]  flush = '0;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic               out_ready = 1'b1;

    logic [STAGES-1:0]        sv_c, sv_s;
    logic [STAGES*WIDTH-1:0]  sd_c, sd_s;
    logic [2:0]               occ_c, occ_s;
    logic [3:0]               cnt_c;
    logic [15:0]              cnt_s;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_c[$];
    logic [WIDTH-1:0] exp_s[$];

    pipe_stage_chain_if #(.WIDTH(WIDTH)) bus_c ();
    pipe_stage_chain_if #(.WIDTH(WIDTH)) bus_s ();

    assign bus_c.in_valid_i  = in_valid;
    assign bus_c.in_data_i   = in_data;
    assign bus_c.out_ready_i = out_ready;
    assign bus_s.in_valid_i  = in_valid;
    assign bus_s.in_data_i   = in_data;
    assign bus_s.out_ready_i = out_ready;

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .COLLAPSE(1'b1), .CNT_W(4)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .bus(bus_c),
        .stall_i(stall), .flush_i(flush), .stage_valid_o(sv_c), .stage_data_o(sd_c),
        .occupancy_o(occ_c), .stall_cnt_o(cnt_c)
    );

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .COLLAPSE(1'b0), .CNT_W(16)) dut_s (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .bus(bus_s),
        .stall_i(stall), .flush_i(flush), .stage_valid_o(sv_s), .stage_data_o(sd_s),
        .occupancy_o(occ_s), .stall_cnt_o(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d,
                                  input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl,
                                  input logic rdy, input int cycles);
        in_valid  = v;
        in_data   = d;
        stall     = st;
        flush     = fl;
        out_ready = rdy;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: every accepted output item is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_c.out_valid_o && out_ready) begin
                if (exp_c.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_c unexpected item actual=%0h required=none",
                             bus_c.out_data_o);
                end else begin
                    check_output("out_c", 64'(bus_c.out_data_o), 64'(exp_c.pop_front()));
                end
            end
            if (bus_s.out_valid_o && out_ready) begin
                if (exp_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_s unexpected item actual=%0h required=none",
                             bus_s.out_data_o);
                end else begin
                    check_output("out_s", 64'(bus_s.out_data_o), 64'(exp_s.pop_front()));
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_output("rst_valid_c", 64'(sv_c), 64'h0);
        check_output("rst_data_c", 64'(sd_c), 64'h0);
        check_output("rst_occ_c", 64'(occ_c), 64'h0);
        check_output("rst_cnt_c", 64'(cnt_c), 64'h0);
        check_output("rst_ready_c", 64'(bus_c.in_ready_o), 64'h1);
        check_output("rst_outv_s", 64'(bus_s.out_valid_o), 64'h0);
        start = 1'b0;
        #1;
        check_output("rst_ready_nostart", 64'(bus_c.in_ready_o), 64'h0);
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill: three items, free-flowing output.
        exp_c.push_back(32'h11); exp_c.push_back(32'h22); exp_c.push_back(32'h33);
        exp_s.push_back(32'h11); exp_s.push_back(32'h22); exp_s.push_back(32'h33);
        apply_stimulus(1'b1, 32'h11, '0, '0, 1'b1, 1);
        apply_stimulus(1'b1, 32'h22, '0, '0, 1'b1, 1);
        apply_stimulus(1'b1, 32'h33, '0, '0, 1'b1, 1);
        check_output("fill_occ_c", 64'(occ_c), 64'd3);
        check_output("fill_occ_s", 64'(occ_s), 64'd3);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 1);
        check_output("fill_outv_c", 64'(bus_c.out_valid_o), 64'h1);
        check_output("fill_outd_c", 64'(bus_c.out_data_o), 64'h11);
        check_output("fill_sv_c", 64'(sv_c), 64'b1110);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 4);
        check_output("fill_empty_c", 64'(occ_c), 64'd0);

        // Stall stage 2 of a full chain for two cycles while stage 3 drains.
        for (int i = 0; i < 5; i++) begin
            exp_c.push_back(32'hA0 + 32'(i));
            exp_s.push_back(32'hA0 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'hA0 + 32'(i), '0, '0, 1'b0, 1);
        end
        check_output("full_sv_c", 64'(sv_c), 64'b1111);
        check_output("full_ready_c", 64'(bus_c.in_ready_o), 64'h0);
        apply_stimulus(1'b1, 32'hA4, 4'b0100, '0, 1'b1, 1);
        check_output("stall_outv_c", 64'(bus_c.out_valid_o), 64'h0);
        check_output("stall_sv_c", 64'(sv_c), 64'b0111);
        check_output("stall_ready_c", 64'(bus_c.in_ready_o), 64'h0);
        check_output("stall_sv_s", 64'(sv_s), 64'b0111);
        apply_stimulus(1'b1, 32'hA4, 4'b0100, '0, 1'b1, 1);
        check_output("stall_cnt_c", 64'(cnt_c), 64'd2);
        check_output("stall_cnt_s", 64'(cnt_s), 64'd2);
        check_output("stall_sv2_s", 64'(sv_s), 64'b0111);
        check_output("stall_outv_s", 64'(bus_s.out_valid_o), 64'h0);
        apply_stimulus(1'b1, 32'hA4, '0, '0, 1'b1, 1);
        check_output("resume_sv_c", 64'(sv_c), 64'b1111);

        // Open a bubble in stage 2, then stall it with the output blocked.
        apply_stimulus(1'b0, '0, 4'b0010, '0, 1'b1, 1);
        check_output("bubble_sv_c", 64'(sv_c), 64'b1011);
        check_output("bubble_sv_s", 64'(sv_s), 64'b1011);
        apply_stimulus(1'b0, '0, 4'b0100, '0, 1'b0, 1);
        check_output("squeeze_sv_c", 64'(sv_c), 64'b1110);
        check_output("squeeze_d2_c", 64'(sd_c[2*WIDTH +: WIDTH]), 64'hA3);
        check_output("squeeze_ready_c", 64'(bus_c.in_ready_o), 64'h1);
        check_output("strict_sv_s", 64'(sv_s), 64'b1011);
        check_output("strict_d1_s", 64'(sd_s[1*WIDTH +: WIDTH]), 64'hA3);
        check_output("strict_ready_s", 64'(bus_s.in_ready_o), 64'h0);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 5);
        check_output("drain_occ_c", 64'(occ_c), 64'd0);
        check_output("drain_occ_s", 64'(occ_s), 64'd0);

        // Flush the two youngest stages; C0/C1 must survive.
        exp_c.push_back(32'hC0); exp_c.push_back(32'hC1);
        exp_s.push_back(32'hC0); exp_s.push_back(32'hC1);
        apply_stimulus(1'b1, 32'hC0, '0, '0, 1'b0, 1);
        apply_stimulus(1'b1, 32'hC1, '0, '0, 1'b0, 1);
        apply_stimulus(1'b1, 32'hB0, '0, '0, 1'b0, 1);
        apply_stimulus(1'b1, 32'hB1, '0, '0, 1'b0, 1);
        check_output("preflush_occ_c", 64'(occ_c), 64'd4);
        apply_stimulus(1'b0, '0, '0, 4'b0011, 1'b0, 1);
        check_output("flush_sv_c", 64'(sv_c), 64'b1100);
        check_output("flush_occ_c", 64'(occ_c), 64'd2);
        check_output("flush_d3_c", 64'(sd_c[3*WIDTH +: WIDTH]), 64'hC0);
        check_output("flush_d2_c", 64'(sd_c[2*WIDTH +: WIDTH]), 64'hC1);
        check_output("flush_sv_s", 64'(sv_s), 64'b1100);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 3);

        // Load and flush stage 0 together: the item is dropped.
        apply_stimulus(1'b1, 32'h99, '0, 4'b0001, 1'b1, 1);
        check_output("flushload_sv_c", 64'(sv_c), 64'b0000);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, 1);
        check_output("flushload_sv2_c", 64'(sv_c), 64'b0000);
        check_output("flushload_sv2_s", 64'(sv_s), 64'b0000);

        // Freeze with start low, then an asynchronous reset between edges.
        apply_stimulus(1'b1, 32'hD0, '0, '0, 1'b0, 1);
        apply_stimulus(1'b1, 32'hD1, '0, '0, 1'b0, 1);
        start = 1'b0;
        apply_stimulus(1'b1, 32'hEE, '0, '0, 1'b1, 3);
        check_output("freeze_sv_c", 64'(sv_c), 64'b0011);
        check_output("freeze_d0_c", 64'(sd_c[0 +: WIDTH]), 64'hD1);
        check_output("freeze_d1_c", 64'(sd_c[WIDTH +: WIDTH]), 64'hD0);
        check_output("freeze_ready_c", 64'(bus_c.in_ready_o), 64'h0);
        check_output("freeze_cnt_c", 64'(cnt_c), 64'd5);
        check_output("freeze_cnt_s", 64'(cnt_s), 64'd5);
        check_output("freeze_sv_s", 64'(sv_s), 64'b0011);
        #3 rst_n = 1'b0;
        #1;
        check_output("arst_sv_c", 64'(sv_c), 64'h0);
        check_output("arst_cnt_c", 64'(cnt_c), 64'h0);
        check_output("arst_occ_c", 64'(occ_c), 64'h0);
        check_output("arst_data_c", 64'(sd_c), 64'h0);
        check_output("arst_sv_s", 64'(sv_s), 64'h0);
        check_output("arst_cnt_s", 64'(cnt_s), 64'h0);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_output("post_rst_ready_c", 64'(bus_c.in_ready_o), 64'h1);

        // Saturation: 4 accepts, then 36 blocked cycles.
        apply_stimulus(1'b1, 32'h55, '0, '0, 1'b0, 40);
        check_output("sat_cnt_c", 64'(cnt_c), 64'd15);
        check_output("sat_cnt_s", 64'(cnt_s), 64'd36);
        check_output("sat_ready_c", 64'(bus_c.in_ready_o), 64'h0);
        check_output("sat_sv_c", 64'(sv_c), 64'b1111);

        check_output("sb_left_c", 64'(exp_c.size()), 64'd0);
        check_output("sb_left_s", 64'(exp_s.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
